// File: rtl/dmem_wb_bridge_pkg.sv
// Shared configuration for the data-memory to Wishbone bridge:
// bus widths, FSM state encodings and the latched request record.
package dmem_wb_bridge_pkg;

  localparam int RW         = 16;
  localparam int ADDR_BYTES = 2;

  typedef enum logic [1:0] {
    DMEM_S_IDLE = 2'd0,
    DMEM_S_BUS  = 2'd1,
    DMEM_S_RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic                  we;
    logic [RW-1:0]         addr;
    logic [RW-1:0]         data;
    logic [ADDR_BYTES-1:0] sel;
  } dmem_req_t;

endpackage

// File: rtl/dmem_wb_bridge.sv
// Core data-memory req/ack handshake to a Wishbone classic master, one transaction at a time.
// Optional bus timeout enabled by defining DMEM_TIMEOUT_EN.
module dmem_wb_bridge
  import dmem_wb_bridge_pkg::*;
#(
  parameter int WB_AW     = 24,
  parameter int TIMEOUT_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mem_req,
  input  logic                  i_mem_we,
  input  logic [RW-1:0]         i_mem_addr,
  input  logic [RW-1:0]         i_mem_data,
  input  logic [ADDR_BYTES-1:0] i_mem_sel,
  input  logic                  i_c_data_page,
  input  logic [7:0]            i_page,
  output logic [RW-1:0]         o_mem_data,
  output logic                  o_mem_ack,
  output logic                  o_mem_exception,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [WB_AW-1:0]      wb_adr,
  output logic [RW-1:0]         wb_dat_o,
  output logic [ADDR_BYTES-1:0] wb_sel,
  input  logic [RW-1:0]         wb_dat_i,
  input  logic                  wb_ack,
  input  logic                  wb_err
);

  localparam int PW = WB_AW - 17;

  dmem_state_e     state_q, state_d;
  dmem_req_t       req_q, req_d;
  logic [PW-1:0]   page_q, page_d;
  logic            abort_q, abort_d;
  logic [RW-1:0]   mem_data_q, mem_data_d;
  logic            mem_ack_q, mem_ack_d;
  logic            mem_exc_q, mem_exc_d;
  logic            term;
  logic            expire;

  // Page is zero-extended or truncated to fit the bits above the word address.
  logic [PW+7:0]   page_wide;
  logic [PW-1:0]   page_in;
  logic            unused_page_hi;
  assign page_wide      = {{PW{1'b0}}, i_page};
  assign page_in        = i_c_data_page ? page_wide[PW-1:0] : '0;
  assign unused_page_hi = ^page_wide[PW+7:PW];

  assign term = wb_ack | wb_err;

`ifdef DMEM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;
  // Fires in the BUS cycle where the running count reaches all-ones.
  assign expire  = (state_q == DMEM_S_BUS) && (&cnt_inc);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == DMEM_S_IDLE && i_mem_req) cnt_d = '0;
    else if (state_q == DMEM_S_BUS)          cnt_d = cnt_inc;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_w;
  assign expire           = 1'b0;
  assign unused_timeout_w = (TIMEOUT_W > 0);
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= DMEM_S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      DMEM_S_IDLE: if (i_mem_req) state_d = DMEM_S_BUS;
      DMEM_S_BUS:  if (term || expire) state_d = DMEM_S_RESP;
      DMEM_S_RESP: state_d = DMEM_S_IDLE;
      default:     state_d = DMEM_S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    req_d      = req_q;
    page_d     = page_q;
    abort_d    = abort_q;
    mem_data_d = mem_data_q;
    mem_ack_d  = 1'b0;
    mem_exc_d  = 1'b0;
    case (state_q)
      DMEM_S_IDLE: begin
        if (i_mem_req) begin
          req_d.we   = i_mem_we;
          req_d.addr = i_mem_addr;
          req_d.data = i_mem_data;
          req_d.sel  = i_mem_sel;
          page_d     = page_in;
          abort_d    = 1'b0;
        end
      end
      DMEM_S_BUS: begin
        if (!i_mem_req) abort_d = 1'b1;
        // A flushed request still finishes on the bus but is never acked.
        if ((term || expire) && !abort_q && i_mem_req) begin
          mem_ack_d  = 1'b1;
          mem_exc_d  = wb_err | ~wb_ack;
          mem_data_d = (wb_err || !wb_ack || req_q.we) ? '0 : wb_dat_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      req_q      <= '0;
      page_q     <= '0;
      abort_q    <= 1'b0;
      mem_data_q <= '0;
      mem_ack_q  <= 1'b0;
      mem_exc_q  <= 1'b0;
    end else begin
      req_q      <= req_d;
      page_q     <= page_d;
      abort_q    <= abort_d;
      mem_data_q <= mem_data_d;
      mem_ack_q  <= mem_ack_d;
      mem_exc_q  <= mem_exc_d;
    end
  end

  assign wb_cyc          = (state_q == DMEM_S_BUS);
  assign wb_stb          = (state_q == DMEM_S_BUS);
  assign wb_we           = req_q.we;
  assign wb_adr          = {page_q, req_q.addr, 1'b0};
  assign wb_dat_o        = req_q.data;
  assign wb_sel          = req_q.sel;
  assign o_mem_data      = mem_data_q;
  assign o_mem_ack       = mem_ack_q;
  assign o_mem_exception = mem_exc_q;

endmodule

// File: tb/tb_dmem_wb_bridge.sv
// Directed self-checking bench for dmem_wb_bridge; covers reads, paged writes,
// bus errors, abort, timeout behaviour (either build) and async reset mid-cycle.
module tb_dmem_wb_bridge;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_mem_req, i_mem_we, i_c_data_page;
  logic [15:0] i_mem_addr, i_mem_data;
  logic [1:0]  i_mem_sel;
  logic [7:0]  i_page;
  logic [15:0] o_mem_data;
  logic        o_mem_ack, o_mem_exception;
  logic        wb_cyc, wb_stb, wb_we;
  logic [23:0] wb_adr;
  logic [15:0] wb_dat_o, wb_dat_i;
  logic [1:0]  wb_sel;
  logic        wb_ack, wb_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  dmem_wb_bridge #(.WB_AW(24), .TIMEOUT_W(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr),
    .i_mem_data(i_mem_data), .i_mem_sel(i_mem_sel),
    .i_c_data_page(i_c_data_page), .i_page(i_page),
    .o_mem_data(o_mem_data), .o_mem_ack(o_mem_ack), .o_mem_exception(o_mem_exception),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [15:0] addr, input logic [15:0] data,
                           input logic [1:0] sel, input logic paged, input logic [7:0] page);
    i_mem_req = 1'b1; i_mem_we = we; i_mem_addr = addr; i_mem_data = data;
    i_mem_sel = sel; i_c_data_page = paged; i_page = page;
  endtask

  int bus_cycles, acks;
  logic exc_seen;
  logic [15:0] data_seen;

  initial begin
    i_rst = 1'b0; i_mem_req = 0; i_mem_we = 0; i_mem_addr = 0; i_mem_data = 0;
    i_mem_sel = 0; i_c_data_page = 0; i_page = 0; wb_dat_i = 0; wb_ack = 0; wb_err = 0;
    #2;
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_ack", o_mem_ack, 0);
    chk("rst_exc", o_mem_exception, 0);
    chk("rst_data", o_mem_data, 0);
    chk("rst_adr", wb_adr, 0);
    tick(); tick();
    i_rst = 1'b1;

    // zero-wait read
    start_req(1'b0, 16'h1234, 16'h0000, 2'b11, 1'b0, 8'h00);
    tick();
    chk("rd_cyc", wb_cyc, 1);
    chk("rd_stb", wb_stb, 1);
    chk("rd_adr", wb_adr, 24'h002468);
    chk("rd_we", wb_we, 0);
    chk("rd_ack_early", o_mem_ack, 0);
    wb_ack = 1'b1; wb_dat_i = 16'hBEEF;
    tick();
    chk("rd_ack", o_mem_ack, 1);
    chk("rd_data", o_mem_data, 16'hBEEF);
    chk("rd_exc", o_mem_exception, 0);
    chk("rd_cyc_drop", wb_cyc, 0);
    wb_ack = 0; i_mem_req = 0;
    tick();
    chk("rd_ack_pulse", o_mem_ack, 0);
    chk("rd_data_hold", o_mem_data, 16'hBEEF);

    // paged write with three wait states; inputs change during BUS
    start_req(1'b1, 16'h0010, 16'hA55A, 2'b01, 1'b1, 8'h05);
    tick();
    chk("wr_adr", wb_adr, 24'h0A0020);
    chk("wr_we", wb_we, 1);
    chk("wr_dat", wb_dat_o, 16'hA55A);
    chk("wr_sel", wb_sel, 2'b01);
    i_mem_addr = 16'hFFFF; i_mem_data = 16'h0000; i_mem_sel = 2'b10; i_page = 8'h7F;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (o_mem_ack) acks++;
    end
    chk("wr_wait_acks", acks, 0);
    chk("wr_wait_cyc", wb_cyc, 1);
    chk("wr_adr_held", wb_adr, 24'h0A0020);
    wb_ack = 1'b1; wb_dat_i = 16'h1234;
    tick();
    chk("wr_ack", o_mem_ack, 1);
    chk("wr_data0", o_mem_data, 0);
    wb_ack = 0; i_mem_req = 0;
    tick();
    chk("wr_single_ack", o_mem_ack, 0);

    // bus error with simultaneous ack: error wins
    start_req(1'b0, 16'h0003, 16'h0000, 2'b11, 1'b0, 8'h00);
    tick();
    wb_err = 1'b1; wb_ack = 1'b1; wb_dat_i = 16'hFFFF;
    tick();
    chk("err_ack", o_mem_ack, 1);
    chk("err_exc", o_mem_exception, 1);
    chk("err_data", o_mem_data, 0);
    wb_err = 0; wb_ack = 0; i_mem_req = 0;
    tick();
    chk("err_exc_pulse", o_mem_exception, 0);
    start_req(1'b0, 16'h0100, 16'h0000, 2'b11, 1'b0, 8'h00);
    tick();
    chk("post_err_adr", wb_adr, 24'h000200);
    wb_ack = 1'b1; wb_dat_i = 16'h1357;
    tick();
    chk("post_err_ack", o_mem_ack, 1);
    chk("post_err_data", o_mem_data, 16'h1357);
    chk("post_err_exc", o_mem_exception, 0);
    wb_ack = 0; i_mem_req = 0;
    tick();

    // abort: request dropped while on the bus
    start_req(1'b0, 16'h0042, 16'h0000, 2'b11, 1'b0, 8'h00);
    tick();
    i_mem_req = 0;
    tick();
    chk("abort_cyc", wb_cyc, 1);
    wb_ack = 1'b1; wb_dat_i = 16'h7777;
    tick();
    chk("abort_noack", o_mem_ack, 0);
    chk("abort_cyc_drop", wb_cyc, 0);
    chk("abort_data_hold", o_mem_data, 16'h1357);
    wb_ack = 0;
    tick();
    chk("abort_noack2", o_mem_ack, 0);

    // no terminate ever
    start_req(1'b0, 16'h0005, 16'h0000, 2'b11, 1'b0, 8'h00);
    tick();
    bus_cycles = 0; acks = 0; exc_seen = 0; data_seen = 16'hDEAD;
    for (int i = 0; i < 100; i++) begin
      if (wb_cyc) bus_cycles++;
      if (o_mem_ack) begin
        acks++; exc_seen = o_mem_exception; data_seen = o_mem_data; i_mem_req = 0;
      end
      tick();
    end
`ifdef DMEM_TIMEOUT_EN
    chk("to_cycles", bus_cycles, 15);
    chk("to_acks", acks, 1);
    chk("to_exc", exc_seen, 1);
    chk("to_data", data_seen, 0);
`else
    chk("noto_cycles", bus_cycles, 100);
    chk("noto_acks", acks, 0);
    chk("noto_cyc", wb_cyc, 1);
`endif
    if (wb_cyc) begin
      wb_ack = 1'b1; wb_dat_i = 16'h0000;
      tick();
      wb_ack = 0;
    end
    i_mem_req = 0;
    tick(); tick();

    // async reset during BUS with a pending ack
    start_req(1'b0, 16'h0777, 16'h0000, 2'b11, 1'b0, 8'h00);
    tick();
    chk("rstmid_cyc_pre", wb_cyc, 1);
    wb_ack = 1'b1; wb_dat_i = 16'h5555;
    #2;
    i_rst = 1'b0;
    #1;
    chk("rstmid_cyc", wb_cyc, 0);
    chk("rstmid_stb", wb_stb, 0);
    chk("rstmid_ack", o_mem_ack, 0);
    tick();
    chk("rstmid_ack_edge", o_mem_ack, 0);
    chk("rstmid_data", o_mem_data, 0);
    wb_ack = 0; i_mem_req = 0;
    i_rst = 1'b1;
    tick();
    // page 0xFF truncates to 7 bits above the word address
    start_req(1'b0, 16'h0001, 16'h0000, 2'b11, 1'b1, 8'hFF);
    tick();
    chk("rstpost_adr", wb_adr, 24'hFE0002);
    wb_ack = 1'b1; wb_dat_i = 16'h2222;
    tick();
    chk("rstpost_ack", o_mem_ack, 1);
    chk("rstpost_data", o_mem_data, 16'h2222);
    wb_ack = 0; i_mem_req = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
